ex_mem_data_stage: RTL

EX_MEM_DATA_STAGE -- requirements
Module: ex_mem_data_stage

---
 rtl/ex_mem_pkg.sv | 17 +
 rtl/ex_mem_chan_sel.sv | 24 ++
 rtl/ex_mem_data_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX/MEM data stage: default channel geometry
// and the per-channel select encodings.
package ex_mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CH = 2;

  // Select encodings: which source feeds a channel of the stage register
  localparam logic SEL_IDEX = 1'b0;
  localparam logic SEL_ALU  = 1'b1;

  // Bit offset of channel idx inside a packed multi-channel bus
  function automatic int chan_lsb(input int idx, input int data_w);
    return idx * data_w;
  endfunction

endpackage

// File: rtl/ex_mem_chan_sel.sv
// One channel of the EX/MEM data select: picks the ALU result or the
// ID/EX register value for a single DATA_W-wide channel.
module ex_mem_chan_sel
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] id_ex_data,
  input  logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] data
);

  // 2:1 source select for this channel
  always_comb begin
    data = id_ex_data;
    if (sel == SEL_ALU) begin
      data = alu_res;
    end else begin
      data = id_ex_data;
    end
  end

endmodule

// File: rtl/ex_mem_data_stage.sv
// EX/MEM data stage: captures per-channel selected data into a registered
// valid/ready pipeline stage.
// Build option: define EX_MEM_SKID_BUF_EN to add a one-entry skid buffer so
// in_ready comes purely from a register (max occupancy 2). Without it the
// stage is a single output register whose in_ready depends on out_ready.
module ex_mem_data_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH-1:0]        sel,
  input  logic [NUM_CH*DATA_W-1:0] id_ex_data,
  input  logic [NUM_CH*DATA_W-1:0] alu_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_sel
);

  logic [NUM_CH*DATA_W-1:0] sel_data;
  logic                     out_valid_r;
  logic [NUM_CH*DATA_W-1:0] out_data_r;
  logic [NUM_CH-1:0]        out_sel_r;
  logic                     accept;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    ex_mem_chan_sel #(.DATA_W(DATA_W)) u_chan_sel (
      .sel        (sel[i]),
      .id_ex_data (id_ex_data[chan_lsb(i, DATA_W) +: DATA_W]),
      .alu_res    (alu_res[chan_lsb(i, DATA_W) +: DATA_W]),
      .data       (sel_data[chan_lsb(i, DATA_W) +: DATA_W])
    );
  end

`ifdef EX_MEM_SKID_BUF_EN
  logic                     skid_valid_r;
  logic [NUM_CH*DATA_W-1:0] skid_data_r;
  logic [NUM_CH-1:0]        skid_sel_r;

  // Ready only depends on skid occupancy, so it never combinationally follows out_ready
  assign in_ready = !skid_valid_r;
  assign accept   = in_valid && !skid_valid_r;

  // Output slot refills from skid first (keeps order); stalled accepts park in skid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_sel_r    <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_sel_r   <= '0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (!out_valid_r || out_ready) begin
      if (skid_valid_r) begin
        out_data_r   <= skid_data_r;
        out_sel_r    <= skid_sel_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (accept) begin
        out_data_r  <= sel_data;
        out_sel_r   <= sel;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (accept) begin
      skid_data_r  <= sel_data;
      skid_sel_r   <= sel;
      skid_valid_r <= 1'b1;
    end
  end
`else
  // Accept whenever the output register is empty or retiring this cycle
  assign in_ready = !out_valid_r || out_ready;
  assign accept   = in_valid && in_ready;

  // Single output register: load on accept, drop valid on retire, flush clears valid only
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept) begin
      out_data_r  <= sel_data;
      out_sel_r   <= sel;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end
`endif

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule
